ddd_rx: RTL and testbench

- Synthesizable responder for the 3D3444 delay-chip serial port; the chip-side end of the serial_clock / serial_out / adr_latch / serial_in link.
- Oversamples the link on the system clock, shifts in 20-bit frames and latches them into decoded output-enable and delay registers on adr_latch falling edge.
- Drives serial readback so the programmer's verify pass reproduces the previous frame.
- Used in RAT/TMB emulation firmware and as a loop-back partner in board self-test.

---
 rtl/ddd_pkg.sv | 37 +++
 rtl/ddd_sync.sv | 32 +++
 rtl/ddd_rx.sv | 109 ++++++++++
 tb/tb_ddd_rx.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddd_pkg.sv
// Shared definitions for the 3D3444 delay-chip serial link.
// Used by the responder, the programmer block and benches.
package ddd_pkg;

  localparam int unsigned FRAME_BITS  = 20;
  localparam int unsigned FIELD_W     = 4;
  localparam int unsigned BIT_CNT_W   = 5;
  localparam int unsigned BIT_CNT_MAX = 31;

  localparam int unsigned OE_LSB  = 0;
  localparam int unsigned CH0_LSB = 4;
  localparam int unsigned CH1_LSB = 8;
  localparam int unsigned CH2_LSB = 12;
  localparam int unsigned CH3_LSB = 16;

  typedef logic [FRAME_BITS-1:0] frame_t;

  typedef struct packed {
    logic [FIELD_W-1:0] oe;
    logic [FIELD_W-1:0] ch0;
    logic [FIELD_W-1:0] ch1;
    logic [FIELD_W-1:0] ch2;
    logic [FIELD_W-1:0] ch3;
  } ddd_cfg_t;

  // Each field arrives MSB first, so its MSB sits at the lowest frame index.
  function automatic ddd_cfg_t decode_frame(frame_t f);
    ddd_cfg_t c;
    c.oe  = {f[OE_LSB],  f[OE_LSB+1],  f[OE_LSB+2],  f[OE_LSB+3]};
    c.ch0 = {f[CH0_LSB], f[CH0_LSB+1], f[CH0_LSB+2], f[CH0_LSB+3]};
    c.ch1 = {f[CH1_LSB], f[CH1_LSB+1], f[CH1_LSB+2], f[CH1_LSB+3]};
    c.ch2 = {f[CH2_LSB], f[CH2_LSB+1], f[CH2_LSB+2], f[CH2_LSB+3]};
    c.ch3 = {f[CH3_LSB], f[CH3_LSB+1], f[CH3_LSB+2], f[CH3_LSB+3]};
    return c;
  endfunction

endpackage

// File: rtl/ddd_sync.sv
// Multi-stage synchronizer with selectable reset level and edge strobes.
// Edges are taken against one extra flop behind the synchronized output.
module ddd_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic gbl_reset_n,
  input  logic rst_val,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   q_d;

  always_ff @(posedge clock or negedge gbl_reset_n) begin
    if (!gbl_reset_n) begin
      chain <= {SYNC_STAGES{rst_val}};
      q_d   <= rst_val;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
      q_d   <= chain[SYNC_STAGES-1];
    end
  end

  assign q      = chain[SYNC_STAGES-1];
  assign rise_c = q & ~q_d;
  assign fall_c = ~q & q_d;

endmodule

// File: rtl/ddd_rx.sv
// Chip-side responder for the 3D3444 serial port: shifts in 20-bit frames,
// latches decoded enables/delays on adr_latch fall, and reads the held frame back.
module ddd_rx
  import ddd_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clock,
  input  logic                 gbl_reset_n,
  input  logic                 sclk,
  input  logic                 sdi,
  input  logic                 adr_latch,
  output logic                 sdo,
  output logic [FIELD_W-1:0]   oe,
  output logic [FIELD_W-1:0]   delay_ch0,
  output logic [FIELD_W-1:0]   delay_ch1,
  output logic [FIELD_W-1:0]   delay_ch2,
  output logic [FIELD_W-1:0]   delay_ch3,
  output logic                 loaded,
  output logic                 latch_strobe,
  output logic                 frame_err,
  output logic [BIT_CNT_W-1:0] bit_cnt
);

  logic     sclk_q, sclk_rise_c, sclk_fall_c;
  logic     sdi_q, sdi_rise_c, sdi_fall_c;
  logic     adr_q, adr_rise_c, adr_fall_c;
  logic     sync_unused_c;
  logic     shift_c, collide_c;
  frame_t   sr;
  ddd_cfg_t cfg;

  ddd_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clock       (clock),
    .gbl_reset_n (gbl_reset_n),
    .rst_val     (1'b0),
    .d           (sclk),
    .q           (sclk_q),
    .rise_c      (sclk_rise_c),
    .fall_c      (sclk_fall_c)
  );

  ddd_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdi (
    .clock       (clock),
    .gbl_reset_n (gbl_reset_n),
    .rst_val     (1'b0),
    .d           (sdi),
    .q           (sdi_q),
    .rise_c      (sdi_rise_c),
    .fall_c      (sdi_fall_c)
  );

  // Idles high so reset release never looks like a latch edge.
  ddd_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_adr (
    .clock       (clock),
    .gbl_reset_n (gbl_reset_n),
    .rst_val     (1'b1),
    .d           (adr_latch),
    .q           (adr_q),
    .rise_c      (adr_rise_c),
    .fall_c      (adr_fall_c)
  );

  assign sync_unused_c = ^{sclk_q, sclk_fall_c, sdi_rise_c, sdi_fall_c, adr_rise_c};

  assign shift_c   = sclk_rise_c & adr_q;
  assign collide_c = sclk_rise_c & adr_fall_c;

  // Frame shift, latch and readback; a latch edge pre-empts a coincident shift.
  always_ff @(posedge clock or negedge gbl_reset_n) begin
    if (!gbl_reset_n) begin
      sr           <= '0;
      bit_cnt      <= '0;
      cfg          <= '0;
      loaded       <= 1'b0;
      latch_strobe <= 1'b0;
      frame_err    <= 1'b0;
      sdo          <= 1'b0;
    end else begin
      latch_strobe <= 1'b0;
      sdo          <= sr[0];
      if (adr_fall_c) begin
        bit_cnt <= '0;
        if (bit_cnt == BIT_CNT_W'(FRAME_BITS)) begin
          cfg          <= decode_frame(sr);
          latch_strobe <= 1'b1;
          loaded       <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
        if (collide_c) begin
          frame_err <= 1'b1;
        end
      end else if (shift_c) begin
        sr <= {sdi_q, sr[FRAME_BITS-1:1]};
        if (bit_cnt != BIT_CNT_W'(BIT_CNT_MAX)) begin
          bit_cnt <= bit_cnt + BIT_CNT_W'(1);
        end
      end
    end
  end

  assign oe        = cfg.oe;
  assign delay_ch0 = cfg.ch0;
  assign delay_ch1 = cfg.ch1;
  assign delay_ch2 = cfg.ch2;
  assign delay_ch3 = cfg.ch3;

endmodule

// File: tb/tb_ddd_rx.sv
// Bench for ddd_rx: pin-level programmer stimulus, a bit-queue model of the
// chip's held frame, and a per-cycle compare whenever the link is quiet.
module tb_ddd_rx;
  localparam int unsigned S = 2;

  logic       clock = 1'b0;
  logic       gbl_reset_n, sclk, sdi, adr_latch;
  logic       sdo, loaded, latch_strobe, frame_err;
  logic [3:0] oe, delay_ch0, delay_ch1, delay_ch2, delay_ch3;
  logic [4:0] bit_cnt;

  int checks = 0;
  int failures = 0;
  int strobe_cnt = 0;
  int strobe_run = 0;
  bit settled = 1'b0;

  // Model: last 20 bits received (oldest first) plus the programmed state.
  bit       m_held[$];
  bit [3:0] m_oe;
  bit [3:0] m_ch[4];
  bit       m_loaded, m_err;
  int       m_cnt;
  int       m_strobes = 0;

  ddd_rx #(.SYNC_STAGES(S)) dut (
    .clock        (clock),
    .gbl_reset_n  (gbl_reset_n),
    .sclk         (sclk),
    .sdi          (sdi),
    .adr_latch    (adr_latch),
    .sdo          (sdo),
    .oe           (oe),
    .delay_ch0    (delay_ch0),
    .delay_ch1    (delay_ch1),
    .delay_ch2    (delay_ch2),
    .delay_ch3    (delay_ch3),
    .loaded       (loaded),
    .latch_strobe (latch_strobe),
    .frame_err    (frame_err),
    .bit_cnt      (bit_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] mk(input logic [3:0] o, c0, c1, c2, c3);
    return {o, c0, c1, c2, c3};
  endfunction

  task automatic m_reset();
    m_held = {};
    for (int i = 0; i < 20; i++) m_held.push_back(1'b0);
    m_oe = '0;
    for (int c = 0; c < 4; c++) m_ch[c] = '0;
    m_loaded = 1'b0;
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  task automatic m_shift(input bit b);
    m_held.push_back(b);
    void'(m_held.pop_front());
    if (m_cnt < 31) m_cnt++;
  endtask

  task automatic m_latch(input bit collision);
    if (m_cnt == 20) begin
      m_oe = {m_held[0], m_held[1], m_held[2], m_held[3]};
      for (int c = 0; c < 4; c++)
        m_ch[c] = {m_held[4+4*c], m_held[5+4*c], m_held[6+4*c], m_held[7+4*c]};
      m_loaded = 1'b1;
      m_strobes++;
    end else begin
      m_err = 1'b1;
    end
    if (collision) m_err = 1'b1;
    m_cnt = 0;
  endtask

  // Per-cycle comparison against the model while no link event is in flight.
  always @(negedge clock) begin
    if (settled) begin
      chk("oe", 32'(oe), 32'(m_oe));
      chk("ch0", 32'(delay_ch0), 32'(m_ch[0]));
      chk("ch1", 32'(delay_ch1), 32'(m_ch[1]));
      chk("ch2", 32'(delay_ch2), 32'(m_ch[2]));
      chk("ch3", 32'(delay_ch3), 32'(m_ch[3]));
      chk("loaded", 32'(loaded), 32'(m_loaded));
      chk("frame_err", 32'(frame_err), 32'(m_err));
      chk("bit_cnt", 32'(bit_cnt), 32'(m_cnt));
      chk("sdo", 32'(sdo), 32'(m_held[0]));
      chk("strobe_idle", 32'(latch_strobe), 32'd0);
    end
  end

  always @(negedge clock) begin
    if (latch_strobe) begin
      if (strobe_run == 0) strobe_cnt++;
      strobe_run++;
    end else if (strobe_run != 0) begin
      chk("strobe_width", 32'(strobe_run), 32'd1);
      strobe_run = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic settle();
    repeat (S + 3) @(posedge clock);
    settled = 1'b1;
  endtask

  task automatic do_reset();
    settled = 1'b0;
    #2;
    gbl_reset_n = 1'b0;
    sclk = 1'b0;
    sdi = 1'b0;
    adr_latch = 1'b1;
    #1;
    chk("rst_oe", 32'(oe), 32'd0);
    chk("rst_ch", 32'({delay_ch0, delay_ch1, delay_ch2, delay_ch3}), 32'd0);
    chk("rst_flags", 32'({loaded, latch_strobe, frame_err, sdo}), 32'd0);
    chk("rst_bit_cnt", 32'(bit_cnt), 32'd0);
    m_reset();
    repeat (3) @(negedge clock);
    gbl_reset_n = 1'b1;
    settle();
    chk("no_strobe_at_release", 32'(strobe_cnt), 32'(m_strobes));
  endtask

  task automatic shift_bit(input bit b, input int half);
    settled = 1'b0;
    @(negedge clock);
    sclk = 1'b0;
    sdi = b;
    repeat (half - 1) @(negedge clock);
    @(negedge clock);
    sclk = 1'b1;
    repeat (half - 1) @(negedge clock);
    m_shift(b);
  endtask

  task automatic send_bits(input logic [39:0] v, input int n, input int half);
    logic [39:0] t;
    t = v;
    for (int i = n - 1; i >= 0; i--) shift_bit(t[i], half);
    settle();
  endtask

  task automatic latch_pulse(input int half);
    settled = 1'b0;
    @(negedge clock);
    adr_latch = 1'b0;
    repeat (2 * half) @(negedge clock);
    adr_latch = 1'b1;
    m_latch(1'b0);
    settle();
    chk("strobe_count", 32'(strobe_cnt), 32'(m_strobes));
  endtask

  // sclk rise and adr_latch fall on the same clock, so they sync together.
  task automatic collide();
    settled = 1'b0;
    @(negedge clock);
    sclk = 1'b0;
    sdi = 1'b1;
    repeat (2) @(negedge clock);
    sclk = 1'b1;
    adr_latch = 1'b0;
    repeat (2) @(negedge clock);
    adr_latch = 1'b1;
    m_latch(1'b1);
    settle();
    chk("strobe_count", 32'(strobe_cnt), 32'(m_strobes));
  endtask

  initial begin
    logic [19:0] rb;
    logic [19:0] f;
    bit          exp_old;
    gbl_reset_n = 1'b0;
    sclk = 1'b0;
    sdi = 1'b0;
    adr_latch = 1'b1;

    // Good frame at clock = 2x sclk, then readback of it.
    do_reset();
    send_bits(40'(mk(4'hF, 4'h3, 4'h5, 4'hA, 4'hC)), 20, 1);
    latch_pulse(1);
    chk("p1_oe", 32'(oe), 32'hF);
    chk("p1_ch", 32'({delay_ch0, delay_ch1, delay_ch2, delay_ch3}), 32'h35AC);
    chk("p1_loaded", 32'(loaded), 32'd1);
    chk("p1_err", 32'(frame_err), 32'd0);
    chk("p1_cnt", 32'(bit_cnt), 32'd0);
    chk("p1_strobes", 32'(strobe_cnt), 32'd1);

    rb = '0;
    for (int i = 0; i < 20; i++) begin
      settled = 1'b0;
      exp_old = m_held[0];
      @(negedge clock);
      sclk = 1'b0;
      sdi = 1'b0;
      @(negedge clock);
      sclk = 1'b1;
      m_shift(1'b0);
      repeat (S + 1) @(posedge clock);
      #1;
      chk("sdo_before_latency", 32'(sdo), 32'(exp_old));
      rb = {rb[18:0], sdo};
      @(posedge clock);
      #1;
      chk("sdo_at_latency", 32'(sdo), 32'(m_held[0]));
    end
    settle();
    chk("readback", 32'(rb), 32'h000F35AC);
    chk("rb_cnt", 32'(bit_cnt), 32'd20);
    chk("rb_oe_kept", 32'(oe), 32'hF);

    // 19-bit frame after a good one.
    do_reset();
    send_bits(40'(mk(4'h5, 4'h1, 4'h2, 4'h4, 4'h8)), 20, 2);
    latch_pulse(2);
    f = mk(4'hA, 4'hA, 4'hA, 4'hA, 4'hA);
    send_bits(40'(f[18:0]), 19, 1);
    latch_pulse(1);
    chk("p2_oe", 32'(oe), 32'h5);
    chk("p2_ch", 32'({delay_ch0, delay_ch1, delay_ch2, delay_ch3}), 32'h1248);
    chk("p2_err", 32'(frame_err), 32'd1);
    chk("p2_strobes", 32'(strobe_cnt), 32'd2);

    // 21-bit frame after a good one.
    do_reset();
    send_bits(40'(mk(4'h3, 4'hC, 4'h0, 4'hF, 4'h7)), 20, 1);
    latch_pulse(1);
    send_bits(40'({mk(4'hC, 4'h3, 4'hF, 4'h0, 4'h8), 1'b1}), 21, 1);
    latch_pulse(1);
    chk("p3_oe", 32'(oe), 32'h3);
    chk("p3_ch", 32'({delay_ch0, delay_ch1, delay_ch2, delay_ch3}), 32'hC0F7);
    chk("p3_err", 32'(frame_err), 32'd1);
    chk("p3_loaded", 32'(loaded), 32'd1);

    // Bit counter saturation.
    do_reset();
    send_bits(40'hA5A5_5A5A_F0, 40, 2);
    chk("p4_sat", 32'(bit_cnt), 32'd31);
    latch_pulse(1);
    chk("p4_err", 32'(frame_err), 32'd1);
    chk("p4_loaded", 32'(loaded), 32'd0);
    chk("p4_cnt", 32'(bit_cnt), 32'd0);

    // Shift and latch colliding after 20 good bits.
    do_reset();
    send_bits(40'(mk(4'hA, 4'h6, 4'h9, 4'hE, 4'h1)), 20, 1);
    collide();
    chk("p5_oe", 32'(oe), 32'hA);
    chk("p5_ch", 32'({delay_ch0, delay_ch1, delay_ch2, delay_ch3}), 32'h69E1);
    chk("p5_err", 32'(frame_err), 32'd1);
    chk("p5_loaded", 32'(loaded), 32'd1);
    chk("p5_cnt", 32'(bit_cnt), 32'd0);
    chk("p5_sdo", 32'(sdo), 32'd1);

    // Reset mid-frame, then a clean frame.
    do_reset();
    send_bits(40'(mk(4'h9, 4'h8, 4'h7, 4'h6, 4'h5)), 20, 1);
    latch_pulse(1);
    f = mk(4'h1, 4'h2, 4'h3, 4'h4, 4'h5);
    send_bits(40'(f[19:10]), 10, 1);
    do_reset();
    send_bits(40'(mk(4'h6, 4'hB, 4'hD, 4'h2, 4'h4)), 20, 1);
    latch_pulse(1);
    chk("p6_oe", 32'(oe), 32'h6);
    chk("p6_ch", 32'({delay_ch0, delay_ch1, delay_ch2, delay_ch3}), 32'hBD24);
    chk("p6_loaded", 32'(loaded), 32'd1);
    chk("p6_err", 32'(frame_err), 32'd0);

    settled = 1'b0;
    repeat (2) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
